// File: rtl/exception_unit_multi.sv
// Exception/IRQ controller for the LEGv8 datapath: one sync source plus NSRC masked level IRQs, saves ELR/ESR/ERR.
// Optional per-cause vector table enabled by defining EXC_VECTORED_EN; otherwise ExcVector is the constant VEC_BASE.
module exception_unit_multi #(
  parameter int            N          = 64,
  parameter int            NSRC       = 4,
  parameter logic [N-1:0]  VEC_BASE   = N'('hD8),
  parameter logic [N-1:0]  VEC_STRIDE = N'('h40)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     imem_addr_F,
  input  logic [N-1:0]     NextPC_F,
  input  logic [N-1:0]     PCBranch_EX,
  input  logic             sync_exc,
  input  logic [3:0]       sync_cause,
  input  logic             ERet,
  input  logic [NSRC-1:0]  irq_req,
  input  logic [NSRC-1:0]  irq_mask,
  input  logic [1:0]       mrs_sel,
  output logic             EProc,
  output logic [N-1:0]     ExcVector,
  output logic [N-1:0]     PCBranch_EXP,
  output logic [N-1:0]     readData3_E,
  output logic             ExcAck,
  output logic [NSRC-1:0]  irq_ack,
  output logic             in_handler,
  output logic             double_fault
);

  typedef enum logic {RUN, HANDLER} state_t;

  state_t          state;
  logic [N-1:0]    elr;
  logic [N-1:0]    err;
  logic [3:0]      esr;

  logic [NSRC-1:0] pend;
  logic            pend_any;
  logic [2:0]      pend_idx;
  logic [NSRC-1:0] pend_onehot;
  logic            take_sync;
  logic            take_irq;
  logic            entry;
  logic            dfault;
  logic [3:0]      new_cause;

  // Lowest-index pending line wins: scan downward so the last hit is the smallest index.
  always_comb begin
    pend     = irq_req & irq_mask;
    pend_any = |pend;
    pend_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend[i]) pend_idx = 3'(i);
    end
    pend_onehot = NSRC'(1) << pend_idx;
  end

  always_comb begin
    take_sync = (state == RUN) && (sync_exc || ERet);
    take_irq  = (state == RUN) && !sync_exc && !ERet && pend_any;
    entry     = take_sync || take_irq;
    dfault    = (state == HANDLER) && sync_exc;
    if (sync_exc)  new_cause = sync_cause;
    else if (ERet) new_cause = 4'hF;
    else           new_cause = {1'b1, pend_idx};
  end

  assign EProc        = !reset && (entry || dfault);
  assign PCBranch_EXP = ERet ? elr : PCBranch_EX;
  assign in_handler   = (state == HANDLER);

`ifdef EXC_VECTORED_EN
  logic [3:0] vec_cause;

  // Double-fault redirects reuse the cause already latched in ESR.
  always_comb begin
    vec_cause = entry ? new_cause : esr;
    ExcVector = VEC_BASE + N'(vec_cause) * VEC_STRIDE;
  end
`else
  assign ExcVector = VEC_BASE;
`endif

  always_comb begin
    case (mrs_sel)
      2'd0:    readData3_E = elr;
      2'd1:    readData3_E = {{(N-4){1'b0}}, esr};
      2'd2:    readData3_E = err;
      default: readData3_E = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      elr          <= '0;
      err          <= '0;
      esr          <= '0;
      ExcAck       <= 1'b0;
      irq_ack      <= '0;
      double_fault <= 1'b0;
    end else begin
      ExcAck  <= entry;
      irq_ack <= take_irq ? pend_onehot : '0;
      case (state)
        RUN: begin
          if (entry) begin
            // An IRQ lets the current instruction retire, so return past it.
            elr   <= take_irq ? NextPC_F : imem_addr_F;
            err   <= imem_addr_F;
            esr   <= new_cause;
            state <= HANDLER;
          end
        end
        HANDLER: begin
          if (sync_exc)  double_fault <= 1'b1;
          else if (ERet) state        <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
